blink_timer_ctrl: RTL and testbench

//  Command-driven controller for the display blink timebase. Accepts start/stop/pause/

---
 rtl/blink_timer_ctrl_if.sv | 25 ++
 rtl/blink_timer_ctrl.sv | 134 +++++++++++++
 tb/tb_blink_timer_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/blink_timer_ctrl_if.sv
// rtl/blink_timer_ctrl_if.sv - command handshake bundle between the SW/IR decoder and the blink controller
interface blink_timer_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic [2:0]       cmd_code;
    logic [CNT_W-1:0] cmd_period;
    logic             cmd_ready;

    // Command source (decoder side)
    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_period,
        input  cmd_ready
    );

    // Command sink (controller side)
    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/blink_timer_ctrl.sv
// rtl/blink_timer_ctrl.sv - command-driven blink timebase producing invert level and terminal tick
module blink_timer_ctrl #(
    parameter int CNT_W          = 32,
    parameter int DEFAULT_PERIOD = 3464,
    parameter int MIN_PERIOD     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    blink_timer_ctrl_if.slave    cmd,
    output logic                 invert,
    output logic                 tick,
    output logic [1:0]           state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SHOT  = 2'd3
    } state_t;

    localparam logic [2:0] C_NOP     = 3'd0;
    localparam logic [2:0] C_START   = 3'd1;
    localparam logic [2:0] C_STOP    = 3'd2;
    localparam logic [2:0] C_PAUSE   = 3'd3;
    localparam logic [2:0] C_RESUME  = 3'd4;
    localparam logic [2:0] C_LOAD    = 3'd5;
    localparam logic [2:0] C_ONESHOT = 3'd6;
    localparam logic [2:0] C_CLRINV  = 3'd7;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             inv_q, inv_d;
    logic             tick_q, tick_d;
    logic             ready_q, ready_d;
    logic             accept;
    logic             counting;
    logic             term;
    logic [CNT_W-1:0] load_val;

    assign accept   = cmd.cmd_valid && ready_q;
    assign counting = (st_q == ST_RUN) || (st_q == ST_SHOT);
    // >= rather than == so a stale count above the new limit still recovers
    assign term     = counting && (cnt_q >= (period_q - CNT_W'(1)));
    assign load_val = (cmd.cmd_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : cmd.cmd_period;

    // Next-state: terminal-count effects first, then the accepted command overrides state/cnt
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        inv_d    = inv_q;
        tick_d   = 1'b0;
        ready_d  = 1'b1;

        if (term) begin
            tick_d = 1'b1;
            inv_d  = ~inv_q;
            cnt_d  = '0;
            if (st_q == ST_SHOT) begin
                st_d = ST_IDLE;
            end
        end else if (counting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept) begin
            case (cmd.cmd_code)
                C_START: begin
                    st_d  = ST_RUN;
                    cnt_d = '0;
                end
                C_STOP: begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end
                C_PAUSE: begin
                    // The pausing edge does not advance the count
                    if (st_q == ST_RUN) begin
                        st_d = ST_PAUSE;
                        if (!term) begin
                            cnt_d = cnt_q;
                        end
                    end
                end
                C_RESUME: begin
                    if (st_q == ST_PAUSE) begin
                        st_d = ST_RUN;
                    end
                end
                C_LOAD: begin
                    period_d = load_val;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                end
                C_ONESHOT: begin
                    st_d  = ST_SHOT;
                    cnt_d = '0;
                end
                C_CLRINV: begin
                    inv_d = 1'b0;
                end
                C_NOP: begin
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            inv_q    <= 1'b0;
            tick_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            inv_q    <= inv_d;
            tick_q   <= tick_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign invert        = inv_q;
    assign tick          = tick_q;
    assign state         = st_q;
endmodule

// File: tb/tb_blink_timer_ctrl.sv
// tb/tb_blink_timer_ctrl.sv - randomized and directed bench for blink_timer_ctrl with a deadline-based model
module tb_blink_timer_ctrl;
    logic       clk;
    logic       rst;
    logic       invert;
    logic       tick;
    logic [1:0] state;

    blink_timer_ctrl_if #(.CNT_W(32)) bus ();

    blink_timer_ctrl #(
        .CNT_W(32),
        .DEFAULT_PERIOD(3464),
        .MIN_PERIOD(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (bus.slave),
        .invert (invert),
        .tick   (tick),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: timing kept as absolute edge numbers of the next tick
    int n;
    int m_mode;
    int m_period;
    int m_deadline;
    int m_rem;
    bit m_inv;
    bit m_tick;
    bit m_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_period = 3464;
        m_deadline = 0;
        m_rem    = 0;
        m_inv    = 1'b0;
        m_tick   = 1'b0;
        m_ready  = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tick"},  {31'd0, tick},   {31'd0, m_tick});
        chk({tag, ".inv"},   {31'd0, invert}, {31'd0, m_inv});
        chk({tag, ".state"}, {30'd0, state},  m_mode);
        chk({tag, ".ready"}, {31'd0, bus.cmd_ready}, {31'd0, m_ready});
    endtask

    task automatic model_edge(input bit v, input bit [2:0] c, input int p);
        bit acc;
        bit tk;
        acc = v && m_ready;
        tk  = (m_mode == 1 || m_mode == 3) && (n == m_deadline);
        m_ready = 1'b1;
        if (tk) begin
            m_inv = ~m_inv;
            if (m_mode == 1) m_deadline = n + m_period;
            else m_mode = 0;
        end
        if (acc) begin
            case (c)
                3'd1: begin m_mode = 1; m_deadline = n + m_period; end
                3'd2: m_mode = 0;
                3'd3: if (m_mode == 1) begin
                    m_rem  = tk ? m_period : (m_deadline - n + 1);
                    m_mode = 2;
                end
                3'd4: if (m_mode == 2) begin
                    m_mode = 1;
                    m_deadline = n + m_rem;
                end
                3'd5: begin
                    m_period = (p < 2) ? 2 : p;
                    m_ready  = 1'b0;
                    if (m_mode == 1 || m_mode == 3) m_deadline = n + m_period;
                    if (m_mode == 2) m_rem = m_period;
                end
                3'd6: begin m_mode = 3; m_deadline = n + m_period; end
                3'd7: m_inv = 1'b0;
                default: ;
            endcase
        end
        m_tick = tk;
    endtask

    task automatic step(input string tag, input bit v, input bit [2:0] c, input int p);
        @(negedge clk);
        bus.cmd_valid  = v;
        bus.cmd_code   = c;
        bus.cmd_period = p;
        @(posedge clk);
        n++;
        model_edge(v, c, p);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int k);
        for (int i = 0; i < k; i++) step(tag, 1'b0, 3'd0, 0);
    endtask

    initial begin
        n = 0;
        model_reset();
        rst = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_code   = 3'd0;
        bus.cmd_period = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Default period: two ticks 3464 cycles apart
        step("t1_start", 1'b1, 3'd1, 0);
        idle("t1_run", 3464 * 2 + 3);

        // LOAD 10 then START; ready drops for one cycle after LOAD
        step("t2_load", 1'b1, 3'd5, 10);
        step("t2_blocked", 1'b1, 3'd2, 0);
        step("t2_start", 1'b1, 3'd1, 0);
        idle("t2_run", 35);

        // LOAD 0 clamps to 2
        step("t3_load", 1'b1, 3'd5, 0);
        step("t3_gap", 1'b0, 3'd0, 0);
        step("t3_start", 1'b1, 3'd1, 0);
        idle("t3_run", 8);

        // Pause at cnt=4, resume, tick 6 cycles later
        step("t4_load", 1'b1, 3'd5, 10);
        step("t4_gap", 1'b0, 3'd0, 0);
        step("t4_start", 1'b1, 3'd1, 0);
        idle("t4_pre", 4);
        step("t4_pause", 1'b1, 3'd3, 0);
        idle("t4_frozen", 20);
        step("t4_resume", 1'b1, 3'd4, 0);
        idle("t4_post", 12);

        // One-shot with period 5
        step("t5_stop", 1'b1, 3'd2, 0);
        step("t5_clr", 1'b1, 3'd7, 0);
        step("t5_load", 1'b1, 3'd5, 5);
        step("t5_gap", 1'b0, 3'd0, 0);
        step("t5_shot", 1'b1, 3'd6, 0);
        idle("t5_run", 8);

        // STOP and CLRINV coincident with terminal count (period 3)
        step("t6_load", 1'b1, 3'd5, 3);
        step("t6_gap", 1'b0, 3'd0, 0);
        step("t6_start", 1'b1, 3'd1, 0);
        idle("t6_pre", 2);
        step("t6_stop_term", 1'b1, 3'd2, 0);
        step("t6_start2", 1'b1, 3'd1, 0);
        idle("t6_pre2", 2);
        step("t6_clr_term", 1'b1, 3'd7, 0);
        idle("t6_post", 4);

        // Randomized command stream
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit [2:0] c;
            int p;
            v = ($urandom_range(0, 9) < 3);
            c = 3'($urandom_range(0, 7));
            p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 14));
            step("rand", v, c, p);
        end

        // Asynchronous reset in the middle of RUN
        step("t7_load", 1'b1, 3'd5, 4);
        step("t7_gap", 1'b0, 3'd0, 0);
        step("t7_start", 1'b1, 3'd1, 0);
        idle("t7_run", 9);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 3'd6;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t7_async_rst");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        step("t7_after", 1'b0, 3'd0, 0);
        step("t7_shot", 1'b1, 3'd6, 0);
        idle("t7_post", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
